// File: rtl/change_dispenser.sv
// Coin-pulse transmitter: pays a change amount (nickel units) as quarter/dime/nickel
// pulses in greedy order, skipping empty hoppers, then reports done/short/remainder.
module change_dispenser #(
    parameter int AMT_W = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             q_empty,
    input  logic             d_empty,
    input  logic             n_empty,
    output logic             quarter,
    output logic             dime,
    output logic             nickel,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remainder
);

    // state   | meaning
    // S_IDLE  | ready for a request
    // S_SEL   | sample empty flags, choose next coin
    // S_PULSE | one coin pulse on the output
    // S_GAP   | idle spacing between pulses
    // S_DONE  | done pulse with short/remainder
    typedef enum logic [2:0] {S_IDLE, S_SEL, S_PULSE, S_GAP, S_DONE} state_t;

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

    state_t           state, nxt;
    logic [AMT_W-1:0] rem, rem_nxt;
    logic [GW-1:0]    gap_cnt, gap_nxt;
    logic             q_n, d_n, n_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rem       <= '0;
            gap_cnt   <= '0;
            req_ready <= 1'b1;
            quarter   <= 1'b0;
            dime      <= 1'b0;
            nickel    <= 1'b0;
            done      <= 1'b0;
            short     <= 1'b0;
            remainder <= '0;
        end else begin
            state     <= nxt;
            rem       <= rem_nxt;
            gap_cnt   <= gap_nxt;
            req_ready <= (nxt == S_IDLE);
            quarter   <= q_n;
            dime      <= d_n;
            nickel    <= n_n;
            done      <= (nxt == S_DONE);
            short     <= (nxt == S_DONE) && (rem_nxt != '0);
            remainder <= (nxt == S_DONE) ? rem_nxt : '0;
        end
    end

    // Outputs are registered from next-state values, so the coin chosen in
    // S_SEL appears exactly during the S_PULSE cycle; rem is debited on entry.
    always_comb begin
        nxt     = state;
        rem_nxt = rem;
        gap_nxt = gap_cnt;
        q_n     = 1'b0;
        d_n     = 1'b0;
        n_n     = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    rem_nxt = req_amount;
                    nxt     = (req_amount == '0) ? S_DONE : S_SEL;
                end
            end
            S_SEL: begin
                if (rem >= AMT_W'(5) && !q_empty) begin
                    q_n     = 1'b1;
                    rem_nxt = rem - AMT_W'(5);
                    nxt     = S_PULSE;
                end else if (rem >= AMT_W'(2) && !d_empty) begin
                    d_n     = 1'b1;
                    rem_nxt = rem - AMT_W'(2);
                    nxt     = S_PULSE;
                end else if (rem >= AMT_W'(1) && !n_empty) begin
                    n_n     = 1'b1;
                    rem_nxt = rem - AMT_W'(1);
                    nxt     = S_PULSE;
                end else begin
                    nxt = S_DONE;
                end
            end
            S_PULSE: begin
                if (rem == '0) begin
                    nxt = S_DONE;
                end else if (GAP == 0) begin
                    nxt = S_SEL;
                end else begin
                    nxt     = S_GAP;
                    gap_nxt = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) nxt = S_SEL;
                else gap_nxt = gap_cnt - GW'(1);
            end
            S_DONE: nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

endmodule
